// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin packet arbiter for two streams sharing a 2:1 datapath,
// with a one-deep registered output stage and a beat-count watchdog.
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel_a,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_BEATS - 1);

    state_t           state, state_d;
    logic             prio_b;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept, acc_last, wd, pkt_end, room;
    logic [WIDTH-1:0] acc_data;

    assign room     = !out_valid || out_ready;
    assign a_ready  = (state == OWN_A) && room;
    assign b_ready  = (state == OWN_B) && room;
    assign accept   = (a_valid && a_ready) || (b_valid && b_ready);
    assign acc_data = sel_a ? a_data : b_data;
    assign acc_last = sel_a ? a_last : b_last;
    // watchdog: the beat that reaches MAX_BEATS without last closes the packet itself
    assign wd       = (MAX_BEATS != 0) && accept && !acc_last && (beat_cnt == WD_LAST);
    assign pkt_end  = accept && (acc_last || wd);

    always_comb begin
        state_d = state;
        if (state == IDLE) begin
            if (a_valid && (!b_valid || !prio_b))
                state_d = OWN_A;
            else if (b_valid)
                state_d = OWN_B;
        end else if (pkt_end) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            prio_b    <= 1'b0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sel_a     <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_d;
            err   <= wd;
            if (state_d == OWN_A)
                sel_a <= 1'b1;
            else if (state_d == OWN_B)
                sel_a <= 1'b0;
            if (pkt_end) begin
                prio_b   <= sel_a;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= acc_data;
                out_last  <= acc_last || wd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of arbitration order, backpressure, watchdog and reset.
module tb_rr_mux_arbiter;
    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a_data = 8'h0, b_data = 8'h0;
    logic       a_ready, b_ready, out_valid, out_last, sel_a, err;
    logic [7:0] out_data;

    int         checks = 0, failures = 0, cyc = 0, start = 0;
    logic [8:0] a_q[$], b_q[$], o_q[$], exp_q[$];
    int         o_cyc[$], e_cyc[$], b_fc[$];
    logic       a_pop = 1'b0, b_pop = 1'b0;

    rr_mux_arbiter #(.WIDTH(8), .MAX_BEATS(4), .CNT_W(4)) dut (
        .clk(clk), .rst_(rst_),
        .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .sel_a(sel_a), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        a_pop <= rst_ && a_valid && a_ready;
        b_pop <= rst_ && b_valid && b_ready;
        if (rst_ && out_valid && out_ready) begin
            o_q.push_back({out_last, out_data});
            o_cyc.push_back(cyc);
        end
        if (rst_ && err) e_cyc.push_back(cyc);
        if (rst_ && b_valid && b_ready) b_fc.push_back(cyc);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (a_pop && a_q.size() != 0) void'(a_q.pop_front());
        if (b_pop && b_q.size() != 0) void'(b_q.pop_front());
        a_valid = a_q.size() != 0;
        a_data  = a_valid ? a_q[0][7:0] : 8'h0;
        a_last  = a_valid ? a_q[0][8] : 1'b0;
        b_valid = b_q.size() != 0;
        b_data  = b_valid ? b_q[0][7:0] : 8'h0;
        b_last  = b_valid ? b_q[0][8] : 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_seq(input string pfx, input logic [8:0] e[$]);
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s_beat%0d", pfx, i), 32'(o_q[i]), 32'(e[i]));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (o_q.size() < n && t < 200) begin
            step(1);
            t++;
        end
        if (o_q.size() < n) chk("timeout_out", 32'(o_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        a_q.delete();
        b_q.delete();
        step(2);
        rst_ = 1'b1;
        o_q.delete();
        o_cyc.delete();
        e_cyc.delete();
        b_fc.delete();
    endtask

    initial begin
        #1 rst_ = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_sel_a", 32'(sel_a), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_a_ready", 32'(a_ready), 0);
        chk("rst_b_ready", 32'(b_ready), 0);

        // single packet from A, then prio must have moved to B
        do_reset();
        out_ready = 1'b1;
        start = cyc;
        a_q = '{9'h011, 9'h022, 9'h133};
        wait_out(3);
        exp_q = '{9'h011, 9'h022, 9'h133};
        chk_seq("t1", exp_q);
        chk("t1_latency", 32'(o_cyc[0] - start), 3);
        chk("t1_gap01", 32'(o_cyc[1] - o_cyc[0]), 1);
        chk("t1_gap12", 32'(o_cyc[2] - o_cyc[1]), 1);
        chk("t1_sel_a_hold", 32'(sel_a), 1);
        a_q.push_back(9'h144);
        b_q.push_back(9'h1B4);
        wait_out(5);
        chk("t1_prio_b_first", 32'(o_q[3]), 32'(9'h1B4));
        chk("t1_prio_a_next", 32'(o_q[4]), 32'(9'h144));

        // contention from reset: A wins, bubble, B, then A's re-request
        do_reset();
        out_ready = 1'b1;
        a_q = '{9'h0A0, 9'h1A1, 9'h1A2};
        b_q = '{9'h0B0, 9'h1B1};
        wait_out(5);
        exp_q = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h1A2};
        chk_seq("t2", exp_q);
        chk("t2_bubble", 32'(o_cyc[2] - o_cyc[1]), 2);
        chk("t2_b_first_accept", 32'(b_fc[0]), 32'(o_cyc[1] + 1));

        // backpressure mid-packet
        do_reset();
        out_ready = 1'b1;
        a_q = '{9'h051, 9'h052, 9'h053, 9'h154};
        wait_out(1);
        out_ready = 1'b0;
        #1;
        chk("t3_ready_drop", 32'(a_ready), 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("t3_stall%0d", i), 32'({out_valid, a_ready, out_data}), 32'({1'b1, 1'b0, 8'h52}));
        end
        out_ready = 1'b1;
        wait_out(4);
        exp_q = '{9'h051, 9'h052, 9'h053, 9'h154};
        chk_seq("t3", exp_q);
        chk("t3_gap12", 32'(o_cyc[2] - o_cyc[1]), 1);
        chk("t3_gap23", 32'(o_cyc[3] - o_cyc[2]), 1);
        step(3);
        chk("t3_count", 32'(o_q.size()), 4);

        // watchdog at 4 beats, B takes over, A's remainder follows
        do_reset();
        out_ready = 1'b1;
        a_q = '{9'h061, 9'h062, 9'h063, 9'h064, 9'h065, 9'h066};
        b_q = '{9'h0C1, 9'h1C2};
        wait_out(8);
        exp_q = '{9'h061, 9'h062, 9'h063, 9'h164, 9'h0C1, 9'h1C2, 9'h065, 9'h066};
        chk_seq("t4", exp_q);
        chk("t4_err_count", 32'(e_cyc.size()), 1);
        chk("t4_err_cycle", 32'(e_cyc[0]), 32'(o_cyc[3]));

        // asynchronous reset during B's second beat
        do_reset();
        out_ready = 1'b1;
        b_q = '{9'h0D1, 9'h0D2, 9'h1D3};
        wait_out(1);
        #1 rst_ = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_sel_a", 32'(sel_a), 0);
        chk("t5_a_ready", 32'(a_ready), 0);
        chk("t5_b_ready", 32'(b_ready), 0);
        chk("t5_err", 32'(err), 0);
        do_reset();
        a_q = '{9'h1E1};
        b_q = '{9'h1F1};
        wait_out(2);
        chk("t5_first_a", 32'(o_q[0]), 32'(9'h1E1));
        chk("t5_then_b", 32'(o_q[1]), 32'(9'h1F1));

        // owner idles mid-packet; B must wait
        do_reset();
        out_ready = 1'b1;
        a_q = '{9'h071};
        b_q = '{9'h181};
        wait_out(1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t6_sel_a%0d", i), 32'(sel_a), 1);
            chk($sformatf("t6_b_ready%0d", i), 32'(b_ready), 0);
            step(1);
        end
        a_q.push_back(9'h172);
        wait_out(3);
        exp_q = '{9'h071, 9'h172, 9'h181};
        chk_seq("t6", exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
